// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared FSM state encodings, redirect source enum and reset vector default
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, WAIT = 2'd2, HALT = 2'd3} state_t;
  typedef enum logic [2:0] {SRC_SEQ, SRC_BR, SRC_JMP, SRC_MRET, SRC_TRAP} src_t;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
endpackage

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: priority select trap>mret>jmp>br of redirect target; outputs live flag and target
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            trap,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            live,
  output logic [XLEN-1:0] target
);
  src_t src;
  always_comb begin
    src = trap ? SRC_TRAP : mret ? SRC_MRET : jmp ? SRC_JMP : br_taken ? SRC_BR : SRC_SEQ;
    target = trap ? {mtvec[XLEN-1:2], 2'b00} : mret ? mepc : jmp ? jmp_target : br_taken ? br_target : '0;
  end
  assign live = src != SRC_SEQ;
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch sequencer; drives PC en/npc and imem_req from imem handshake, stall, halt and redirects
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              ILEN      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            halt_req,
  input  logic            resume,
  output logic            pc_en,
  output logic [XLEN-1:0] npc,
  output logic            redir_pend,
  output logic [1:0]      state
);
  state_t state_q, state_n;
  logic pend_q, live, adv;
  logic [XLEN-1:0] pend_tgt_q, tgt;
  pc_redirect_mux #(.XLEN(XLEN)) u_mux (
    .trap(trap), .mtvec(mtvec), .mret(mret), .mepc(mepc),
    .jmp(jmp), .jmp_target(jmp_target), .br_taken(br_taken), .br_target(br_target),
    .live(live), .target(tgt)
  );
  always_comb begin
    adv = imem_ready & ~stall;
    state_n = state_q;
    pc_en = 1'b0;
    imem_req = 1'b0;
    npc = live ? tgt : pend_q ? pend_tgt_q : pc + XLEN'(ILEN);
    unique case (state_q)
      BOOT: begin
        pc_en = 1'b1;
        npc = RESET_VEC;
        state_n = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        pc_en = adv;
        state_n = !imem_ready ? WAIT : (adv && halt_req) ? HALT : FETCH;
      end
      WAIT: begin
        imem_req = 1'b1;
        state_n = imem_ready ? FETCH : WAIT;
      end
      HALT: state_n = (resume || trap) ? FETCH : HALT;
    endcase
    if (rst) begin
      pc_en = 1'b1;
      npc = RESET_VEC;
      imem_req = 1'b0;
    end
  end
  // A live redirect that cannot be applied now is held until the next PC advance; newest wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pend_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q <= state_n;
      if (state_q != BOOT) begin
        if (pc_en) pend_q <= 1'b0;
        else if (live) begin
          pend_q <= 1'b1;
          pend_tgt_q <= tgt;
        end
      end
    end
  end
  assign redir_pend = pend_q;
  assign state = state_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: scoreboard bench for pc_seq_ctrl with a behavioural PC register
module tb_pc_seq_ctrl;
  localparam logic [5:0] ALL = 6'h3F, NNP = 6'h3D;
  localparam logic [1:0] S_BOOT = 2'd0, S_FETCH = 2'd1, S_WAIT = 2'd2, S_HALT = 2'd3;
  typedef struct {
    string       name;
    logic [5:0]  m;
    logic        en;
    logic [31:0] np;
    logic        rq;
    logic [1:0]  st;
    logic        pd;
    logic [31:0] p;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic clk = 0, rst = 1;
  logic [31:0] pc;
  logic imem_req, imem_ready = 1, stall = 0, br_taken = 0, jmp = 0, trap = 0, mret = 0;
  logic halt_req = 0, resume = 0, pc_en, redir_pend;
  logic [31:0] br_target = 0, jmp_target = 0, mtvec = 0, mepc = 0, npc;
  logic [1:0] state;
  always #5 clk = ~clk;
  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_req(imem_req), .imem_ready(imem_ready),
    .stall(stall), .br_taken(br_taken), .br_target(br_target), .jmp(jmp),
    .jmp_target(jmp_target), .trap(trap), .mtvec(mtvec), .mret(mret), .mepc(mepc),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .npc(npc),
    .redir_pend(redir_pend), .state(state)
  );
  always @(posedge clk) if (pc_en) pc <= npc;
  task automatic chk(input string n, input string f, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", n, f, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) chk(e.name, "pc_en", 32'(pc_en), 32'(e.en));
      if (e.m[1]) chk(e.name, "npc", npc, e.np);
      if (e.m[2]) chk(e.name, "imem_req", 32'(imem_req), 32'(e.rq));
      if (e.m[3]) chk(e.name, "state", 32'(state), 32'(e.st));
      if (e.m[4]) chk(e.name, "redir_pend", 32'(redir_pend), 32'(e.pd));
      if (e.m[5]) chk(e.name, "pc", pc, e.p);
    end
  end
  task automatic cyc(input string n, input logic [5:0] m, input logic en, input logic [31:0] np,
                     input logic rq, input logic [1:0] st, input logic pd, input logic [31:0] p);
    exp_t e;
    e.name = n; e.m = m; e.en = en; e.np = np; e.rq = rq; e.st = st; e.pd = pd; e.p = p;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc("rst0", ALL, 1, 0, 0, S_BOOT, 0, 0);
    cyc("rst1", ALL, 1, 0, 0, S_BOOT, 0, 0);
    rst = 0;
    cyc("boot", ALL, 1, 0, 0, S_BOOT, 0, 0);
    cyc("f0", ALL, 1, 32'h4, 1, S_FETCH, 0, 0);
    cyc("f1", ALL, 1, 32'h8, 1, S_FETCH, 0, 32'h4);
    jmp = 1; jmp_target = 32'h100;
    cyc("jmp", ALL, 1, 32'h100, 1, S_FETCH, 0, 32'h8);
    jmp = 0; imem_ready = 0;
    cyc("nr", NNP, 0, 0, 1, S_FETCH, 0, 32'h100);
    cyc("w1", NNP, 0, 0, 1, S_WAIT, 0, 32'h100);
    cyc("w2", NNP, 0, 0, 1, S_WAIT, 0, 32'h100);
    imem_ready = 1;
    cyc("w3", NNP, 0, 0, 1, S_WAIT, 0, 32'h100);
    cyc("f100", ALL, 1, 32'h104, 1, S_FETCH, 0, 32'h100);
    stall = 1; br_taken = 1; br_target = 32'h200;
    cyc("stbr", NNP, 0, 0, 1, S_FETCH, 0, 32'h104);
    br_taken = 0;
    cyc("stpend", NNP, 0, 0, 1, S_FETCH, 1, 32'h104);
    stall = 0;
    cyc("apply", ALL, 1, 32'h200, 1, S_FETCH, 1, 32'h104);
    trap = 1; jmp = 1; br_taken = 1; mtvec = 32'h803; jmp_target = 32'h300; br_target = 32'h400;
    cyc("prio", ALL, 1, 32'h800, 1, S_FETCH, 0, 32'h200);
    trap = 0; mret = 1; mepc = 32'h900;
    cyc("mret", ALL, 1, 32'h900, 1, S_FETCH, 0, 32'h800);
    mret = 0; br_taken = 0; jmp_target = 32'hFFFF_FFFC;
    cyc("jfc", ALL, 1, 32'hFFFF_FFFC, 1, S_FETCH, 0, 32'h900);
    jmp = 0;
    cyc("wrap", ALL, 1, 32'h0, 1, S_FETCH, 0, 32'hFFFF_FFFC);
    halt_req = 1;
    cyc("hreq", ALL, 1, 32'h4, 1, S_FETCH, 0, 32'h0);
    halt_req = 0;
    cyc("halt", NNP, 0, 0, 0, S_HALT, 0, 32'h4);
    trap = 1; mtvec = 32'h40;
    cyc("htrap", NNP, 0, 0, 0, S_HALT, 0, 32'h4);
    trap = 0;
    cyc("hexit", ALL, 1, 32'h40, 1, S_FETCH, 1, 32'h4);
    halt_req = 1;
    cyc("post", ALL, 1, 32'h44, 1, S_FETCH, 0, 32'h40);
    cyc("hign", NNP, 0, 0, 0, S_HALT, 0, 32'h44);
    halt_req = 0; resume = 1;
    cyc("res", NNP, 0, 0, 0, S_HALT, 0, 32'h44);
    resume = 0;
    cyc("resf", ALL, 1, 32'h48, 1, S_FETCH, 0, 32'h44);
    stall = 1; br_taken = 1; br_target = 32'h500;
    cyc("nw0", NNP, 0, 0, 1, S_FETCH, 0, 32'h48);
    br_taken = 0; jmp = 1; jmp_target = 32'h600;
    cyc("nw1", NNP, 0, 0, 1, S_FETCH, 1, 32'h48);
    jmp = 0; stall = 0;
    cyc("newest", ALL, 1, 32'h600, 1, S_FETCH, 1, 32'h48);
    imem_ready = 0;
    cyc("rw0", NNP, 0, 0, 1, S_FETCH, 0, 32'h600);
    br_taken = 1; br_target = 32'h700;
    cyc("rw1", NNP, 0, 0, 1, S_WAIT, 0, 32'h600);
    br_taken = 0; rst = 1;
    cyc("rstw", ALL, 1, 32'h0, 0, S_WAIT, 1, 32'h600);
    rst = 0; imem_ready = 1;
    cyc("rboot", ALL, 1, 32'h0, 0, S_BOOT, 0, 32'h0);
    cyc("rf0", ALL, 1, 32'h4, 1, S_FETCH, 0, 32'h0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
